// File: rtl/sfx_event_scheduler.sv
// Sound-effect scheduler: latches collision edges, arbitrates player > sword > sheep,
// and sequences playback in frame units. Optional macro SFX_PREEMPT_EN enables preemption.
module sfx_event_scheduler #(
  parameter int unsigned DUR_SHEEP   = 8,
  parameter int unsigned DUR_SWORD   = 16,
  parameter int unsigned DUR_PLAYER  = 32,
  parameter int unsigned STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [2:0] req,
  output logic [1:0] sfx_id,
  output logic       sfx_active,
  output logic       sfx_restart,
  output logic [3:0] note_idx,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  localparam logic [3:0] STEP_LAST = 4'(STEP_FRAMES - 1);

  state_e     state_q;
  logic [2:0] req_q;
  logic [2:0] pending_q, pending_d;
  logic [1:0] sfx_id_q;
  logic       sfx_active_q;
  logic       sfx_restart_q;
  logic [3:0] note_idx_q;
  logic [3:0] step_cnt_q;
  logic [7:0] frames_left_q;

  logic [2:0] rise;
  logic [1:0] top_id;
  logic [2:0] grant_clr;
  logic       do_grant;

  function automatic logic [7:0] dur_of(input logic [1:0] id);
    case (id)
      2'd1:    dur_of = 8'(DUR_SHEEP);
      2'd2:    dur_of = 8'(DUR_SWORD);
      2'd3:    dur_of = 8'(DUR_PLAYER);
      default: dur_of = 8'd0;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rise      = req & ~req_q;
    top_id    = 2'd0;
    grant_clr = 3'b000;
    do_grant  = 1'b0;

    if (pending_q[2])      top_id = 2'd3;
    else if (pending_q[1]) top_id = 2'd2;
    else if (pending_q[0]) top_id = 2'd1;

    if (state_q == S_IDLE && top_id != 2'd0) begin
      do_grant = 1'b1;
    end
`ifdef SFX_PREEMPT_EN
    else if (state_q == S_PLAY && top_id > sfx_id_q) begin
      do_grant = 1'b1;
    end
`endif

    if (do_grant) begin
      case (top_id)
        2'd1:    grant_clr = 3'b001;
        2'd2:    grant_clr = 3'b010;
        2'd3:    grant_clr = 3'b100;
        default: grant_clr = 3'b000;
      endcase
    end

    // A rise on the bit being granted re-latches it: set wins over clear.
    pending_d = (pending_q & ~grant_clr) | rise;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_q         <= 3'b000;
      pending_q     <= 3'b000;
      sfx_id_q      <= 2'd0;
      sfx_active_q  <= 1'b0;
      sfx_restart_q <= 1'b0;
      note_idx_q    <= 4'd0;
      step_cnt_q    <= 4'd0;
      frames_left_q <= 8'd0;
    end else begin
      req_q         <= req;
      pending_q     <= pending_d;
      sfx_restart_q <= 1'b0;

      if (do_grant) begin
        // Grant takes precedence over a coincident frame_tick, which is therefore not counted.
        state_q       <= S_PLAY;
        sfx_id_q      <= top_id;
        sfx_active_q  <= 1'b1;
        sfx_restart_q <= 1'b1;
        note_idx_q    <= 4'd0;
        step_cnt_q    <= 4'd0;
        frames_left_q <= dur_of(top_id);
      end else begin
        case (state_q)
          S_PLAY: begin
            if (frame_tick) begin
              if (frames_left_q <= 8'd1) begin
                state_q       <= S_GAP;
                sfx_id_q      <= 2'd0;
                sfx_active_q  <= 1'b0;
                note_idx_q    <= 4'd0;
                step_cnt_q    <= 4'd0;
                frames_left_q <= 8'd0;
              end else begin
                frames_left_q <= frames_left_q - 8'd1;
                if (step_cnt_q >= STEP_LAST) begin
                  step_cnt_q <= 4'd0;
                  if (note_idx_q != 4'hF) note_idx_q <= note_idx_q + 4'd1;
                end else begin
                  step_cnt_q <= step_cnt_q + 4'd1;
                end
              end
            end
          end
          S_GAP: begin
            if (frame_tick) state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sfx_id      = sfx_id_q;
  assign sfx_active  = sfx_active_q;
  assign sfx_restart = sfx_restart_q;
  assign note_idx    = note_idx_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_sfx_event_scheduler.sv
// Directed bench for sfx_event_scheduler: reset, single effect, simultaneous events,
// higher-priority arrival during playback, retrigger, and reset during playback.
module tb_sfx_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [2:0] req;
  logic [1:0] sfx_id;
  logic       sfx_active;
  logic       sfx_restart;
  logic [3:0] note_idx;
  logic [2:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  sfx_event_scheduler #(
    .DUR_SHEEP(8), .DUR_SWORD(16), .DUR_PLAYER(32), .STEP_FRAMES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .req(req),
    .sfx_id(sfx_id), .sfx_active(sfx_active), .sfx_restart(sfx_restart),
    .note_idx(note_idx), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; returns 1 ns after it so outputs are stable and inputs can change.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_req(input logic [2:0] v);
    req = v;
    cyc();
    req = 3'b000;
  endtask

  task automatic check_all(input string tag, input logic [1:0] id, input logic act,
                           input logic rs, input logic [3:0] nt, input logic [2:0] pd);
    check({tag, ".id"},      8'(sfx_id),      8'(id));
    check({tag, ".active"},  8'(sfx_active),  8'(act));
    check({tag, ".restart"}, 8'(sfx_restart), 8'(rs));
    check({tag, ".note"},    8'(note_idx),    8'(nt));
    check({tag, ".pending"}, 8'(pending),     8'(pd));
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; req = 3'b000;
    #1;

    // Reset, idle inputs for 10 cycles.
    cyc(10);
    check_all("reset", 2'd0, 1'b0, 1'b0, 4'd0, 3'b000);
    rst_n = 1'b1;
    cyc(3);
    check_all("idle", 2'd0, 1'b0, 1'b0, 4'd0, 3'b000);

    // Single sheep pulse: pending at N+1, PLAY at N+2.
    pulse_req(3'b001);
    check("sheep.pend_n1", 8'(pending), 8'h01);
    check("sheep.act_n1", 8'(sfx_active), 8'h00);
    cyc();
    check_all("sheep.grant", 2'd1, 1'b1, 1'b1, 4'd0, 3'b000);
    cyc();
    check("sheep.restart_1cyc", 8'(sfx_restart), 8'h00);
    ticks(3);
    check("sheep.note_t3", 8'(note_idx), 8'h00);
    ticks(1);
    check("sheep.note_t4", 8'(note_idx), 8'h01);
    ticks(3);
    check("sheep.act_t7", 8'(sfx_active), 8'h01);
    check("sheep.id_t7", 8'(sfx_id), 8'h01);
    check("sheep.note_t7", 8'(note_idx), 8'h01);
    ticks(1);
    check("sheep.gap_act", 8'(sfx_active), 8'h00);
    check("sheep.gap_id", 8'(sfx_id), 8'h00);
    ticks(1);
    cyc(2);
    check_all("sheep.done", 2'd0, 1'b0, 1'b0, 4'd0, 3'b000);

    // All three in one cycle; frame_tick during the grant cycle is not counted.
    pulse_req(3'b111);
    check("all.pend", 8'(pending), 8'h07);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check_all("all.p_grant", 2'd3, 1'b1, 1'b1, 4'd0, 3'b011);
    ticks(31);
    check("all.p_act_t31", 8'(sfx_active), 8'h01);
    check("all.p_note_t31", 8'(note_idx), 8'h07);
    ticks(1);
    check("all.p_gap", 8'(sfx_active), 8'h00);
    check("all.p_gap_pend", 8'(pending), 8'h03);
    ticks(1);
    check("all.idle_id", 8'(sfx_id), 8'h00);
    cyc();
    check_all("all.w_grant", 2'd2, 1'b1, 1'b1, 4'd0, 3'b001);
    ticks(15);
    check("all.w_act_t15", 8'(sfx_active), 8'h01);
    check("all.w_note_t15", 8'(note_idx), 8'h03);
    ticks(1);
    check("all.w_gap", 8'(sfx_active), 8'h00);
    ticks(1);
    cyc();
    check_all("all.s_grant", 2'd1, 1'b1, 1'b1, 4'd0, 3'b000);
    ticks(8);
    ticks(1);
    cyc(2);
    check_all("all.done", 2'd0, 1'b0, 1'b0, 4'd0, 3'b000);

    // Sword playing, player rises after frame 5.
    pulse_req(3'b010);
    cyc();
    check_all("pre.w_grant", 2'd2, 1'b1, 1'b1, 4'd0, 3'b000);
    ticks(5);
    pulse_req(3'b100);
    check("pre.pend", 8'(pending), 8'h04);
    cyc();
`ifdef SFX_PREEMPT_EN
    check_all("pre.preempt", 2'd3, 1'b1, 1'b1, 4'd0, 3'b000);
`else
    check_all("pre.wait", 2'd2, 1'b1, 1'b0, 4'd1, 3'b100);
    ticks(10);
    check("pre.w_act_t15", 8'(sfx_active), 8'h01);
    check("pre.w_id_t15", 8'(sfx_id), 8'h02);
    ticks(1);
    check("pre.gap_act", 8'(sfx_active), 8'h00);
    check("pre.gap_pend", 8'(pending), 8'h04);
    ticks(1);
    cyc();
    check_all("pre.p_grant", 2'd3, 1'b1, 1'b1, 4'd0, 3'b000);
`endif

    // Player retriggered twice during its own playback: exactly one replay.
    ticks(3);
    pulse_req(3'b100);
    cyc();
    check("rt.pend1", 8'(pending), 8'h04);
    check("rt.no_restart", 8'(sfx_restart), 8'h00);
    ticks(3);
    pulse_req(3'b100);
    cyc();
    check("rt.pend2", 8'(pending), 8'h04);
    ticks(26);
    check("rt.gap_act", 8'(sfx_active), 8'h00);
    ticks(1);
    cyc();
    check_all("rt.replay", 2'd3, 1'b1, 1'b1, 4'd0, 3'b000);
    ticks(32);
    ticks(1);
    cyc(2);
    check_all("rt.no_2nd", 2'd0, 1'b0, 1'b0, 4'd0, 3'b000);

    // Reset at frame 10 of player playback with req[2] held through release.
    req = 3'b100;
    cyc(2);
    check("rst.p_grant", 8'(sfx_id), 8'h03);
    ticks(10);
    check("rst.note_t10", 8'(note_idx), 8'h02);
    rst_n = 1'b0;
    cyc();
    check_all("rst.cleared", 2'd0, 1'b0, 1'b0, 4'd0, 3'b000);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst.rise_pend", 8'(pending), 8'h04);
    req = 3'b000;
    cyc();
    check_all("rst.replay", 2'd3, 1'b1, 1'b1, 4'd0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
